// File: rtl/sb_route_v2.sv
// Switch box with a serial configuration chain and Wilton-style right turns.
// Optional macro SB_OUT_REG_EN registers the out/oe ports for one cycle of latency.
module sb_route_v2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] north_in,
  input  logic [WIDTH-1:0] east_in,
  input  logic [WIDTH-1:0] south_in,
  input  logic [WIDTH-1:0] west_in,
  output logic [WIDTH-1:0] north_out,
  output logic [WIDTH-1:0] east_out,
  output logic [WIDTH-1:0] south_out,
  output logic [WIDTH-1:0] west_out,
  output logic [WIDTH-1:0] north_oe,
  output logic [WIDTH-1:0] east_oe,
  output logic [WIDTH-1:0] south_oe,
  output logic [WIDTH-1:0] west_oe,
  input  logic             config_en,
  input  logic             config_data_in,
  output logic             config_data_out,
  input  logic             config_commit,
  output logic             config_ready,
  output logic             cfg_err,
  output logic             contention,
  output logic             contention_sticky
);

  localparam int CFG_BITS = WIDTH * 8;
  localparam int CW       = $clog2(CFG_BITS + 2);
  localparam int NW       = 4 * WIDTH;

  logic [CFG_BITS-1:0] chain_reg;
  logic [CFG_BITS-1:0] active_reg;
  logic [CW-1:0]       count_reg;
  logic                cfg_err_reg;
  logic                contention_reg;
  logic                sticky_reg;

  logic [NW-1:0] in_flat;
  logic [NW-1:0] out_flat;
  logic [NW-1:0] oe_flat;
  logic [NW-1:0] multi_flat;
  logic [NW-1:0] out_sel;
  logic [NW-1:0] oe_sel;
  logic          commit_ok;
  logic          contention_next;

  // Side index d occupies in_flat[d*WIDTH +: WIDTH]: N=0, E=1, S=2, W=3.
  assign in_flat = {west_in, south_in, east_in, north_in};

  assign config_ready    = (count_reg == CW'(CFG_BITS));
  assign config_data_out = chain_reg[CFG_BITS-1];
  assign commit_ok       = config_commit && !config_en && config_ready;
  assign contention_next = en && (|multi_flat);

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg      <= '1;
      active_reg     <= '1;
      count_reg      <= '0;
      cfg_err_reg    <= 1'b0;
      contention_reg <= 1'b0;
      sticky_reg     <= 1'b0;
    end else begin
      if (config_en) begin
        chain_reg <= {chain_reg[CFG_BITS-2:0], config_data_in};
      end
      // A rejected commit freezes the counter even while shifting.
      if (commit_ok) begin
        active_reg <= chain_reg;
        count_reg  <= '0;
      end else if (config_en && !config_commit && count_reg != CW'(CFG_BITS + 1)) begin
        count_reg <= count_reg + CW'(1);
      end
      if (config_commit && !commit_ok) begin
        cfg_err_reg <= 1'b1;
      end
      contention_reg <= contention_next;
      sticky_reg     <= commit_ok ? 1'b0 : (sticky_reg | contention_next);
    end
  end

  // Each output wire has exactly three candidate sources, one per other side.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_side
      for (gj = 0; gj < WIDTH; gj++) begin : g_wire
        localparam int DL = (gi + 3) % 4;
        localparam int DS = (gi + 2) % 4;
        localparam int DR = (gi + 1) % 4;
        localparam int RW = (gj + WIDTH - 1) % WIDTH;
        logic [3:0] hit;
        logic [3:0] srcv;
        logic       val;

        always_comb begin
          hit      = '0;
          srcv     = '0;
          hit[DL]  = (active_reg[(gj*4+DL)*2 +: 2] == 2'b10);
          srcv[DL] = in_flat[DL*WIDTH + gj];
          hit[DS]  = (active_reg[(gj*4+DS)*2 +: 2] == 2'b01);
          srcv[DS] = in_flat[DS*WIDTH + gj];
          hit[DR]  = (active_reg[(RW*4+DR)*2 +: 2] == 2'b00);
          srcv[DR] = in_flat[DR*WIDTH + RW];
        end

        always_comb begin
          val = 1'b0;
          for (int d = 3; d >= 0; d--) begin
            if (hit[d]) val = srcv[d];
          end
        end

        assign out_flat[gi*WIDTH + gj]   = val;
        assign oe_flat[gi*WIDTH + gj]    = |hit;
        assign multi_flat[gi*WIDTH + gj] = |(hit & (hit - 4'd1));
      end
    end
  endgenerate

`ifdef SB_OUT_REG_EN
  logic [NW-1:0] out_reg;
  logic [NW-1:0] oe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
      oe_reg  <= '0;
    end else begin
      out_reg <= en ? out_flat : '0;
      oe_reg  <= en ? oe_flat  : '0;
    end
  end

  assign out_sel = out_reg;
  assign oe_sel  = oe_reg;
`else
  assign out_sel = en ? out_flat : '0;
  assign oe_sel  = en ? oe_flat  : '0;
`endif

  assign north_out = out_sel[0*WIDTH +: WIDTH];
  assign east_out  = out_sel[1*WIDTH +: WIDTH];
  assign south_out = out_sel[2*WIDTH +: WIDTH];
  assign west_out  = out_sel[3*WIDTH +: WIDTH];
  assign north_oe  = oe_sel[0*WIDTH +: WIDTH];
  assign east_oe   = oe_sel[1*WIDTH +: WIDTH];
  assign south_oe  = oe_sel[2*WIDTH +: WIDTH];
  assign west_oe   = oe_sel[3*WIDTH +: WIDTH];

  assign cfg_err           = cfg_err_reg;
  assign contention        = contention_reg && en;
  assign contention_sticky = sticky_reg;

endmodule

// File: tb/tb_sb_route_v2.sv
// Scoreboard bench for sb_route_v2 (WIDTH=4); expectations queued at stimulus time.
// Define SB_OUT_REG_EN for both bench and RTL to exercise the registered-output build.
module tb_sb_route_v2;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] north_in = '0, east_in = '0, south_in = '0, west_in = '0;
  logic [WIDTH-1:0] north_out, east_out, south_out, west_out;
  logic [WIDTH-1:0] north_oe, east_oe, south_oe, west_oe;
  logic             config_en = 1'b0, config_data_in = 1'b0, config_commit = 1'b0;
  logic             config_data_out, config_ready, cfg_err, contention, contention_sticky;

  logic [15:0] all_oe, all_out;
  assign all_oe  = {north_oe, east_oe, south_oe, west_oe};
  assign all_out = {north_out, east_out, south_out, west_out};

  sb_route_v2 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en),
    .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
    .north_out(north_out), .east_out(east_out), .south_out(south_out), .west_out(west_out),
    .north_oe(north_oe), .east_oe(east_oe), .south_oe(south_oe), .west_oe(west_oe),
    .config_en(config_en), .config_data_in(config_data_in), .config_data_out(config_data_out),
    .config_commit(config_commit), .config_ready(config_ready), .cfg_err(cfg_err),
    .contention(contention), .contention_sticky(contention_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic score(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got %h want nothing", obs);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until out/oe reflect the current inputs and active configuration.
  task automatic settle();
`ifdef SB_OUT_REG_EN
    step();
`else
    #1;
`endif
  endtask

  function automatic logic [31:0] set_sel(input logic [31:0] v, input int w, input int d,
                                          input logic [1:0] c);
    logic [31:0] r;
    r = v;
    r[(w*4+d)*2 +: 2] = c;
    return r;
  endfunction

  // Shifts vec[n-1:0], MSB first.
  task automatic shift_bits(input logic [31:0] vec, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      config_en      = 1'b1;
      config_data_in = vec[i];
      step();
    end
    config_en = 1'b0;
  endtask

  task automatic commit();
    config_commit = 1'b1;
    step();
    config_commit = 1'b0;
  endtask

  logic [31:0] v_turn, v_twist, v_cont, v_other;

  initial begin
    v_turn  = set_sel(32'hFFFF_FFFF, 0, 0, 2'b10);
    v_twist = set_sel(32'hFFFF_FFFF, 3, 2, 2'b00);
    v_other = set_sel(32'hFFFF_FFFF, 1, 0, 2'b01);
    v_cont  = set_sel(set_sel(32'hFFFF_FFFF, 2, 0, 2'b01), 2, 1, 2'b10);

    // Reset state
    step(); step();
    rst = 1'b0;
    en  = 1'b1;
    expect_val("rst_data_out", 1); expect_val("rst_ready", 0); expect_val("rst_err", 0);
    expect_val("rst_cont", 0); expect_val("rst_sticky", 0);
    expect_val("rst_oe", 0); expect_val("rst_out", 0);
    #1;
    score(config_data_out); score(config_ready); score(cfg_err);
    score(contention); score(contention_sticky); score(all_oe); score(all_out);

    // North wire 0 turns left onto east wire 0
    shift_bits(v_turn >> 1, 31);
    expect_val("ready_at_31", 0);
    score(config_ready);
    shift_bits(v_turn, 1);
    expect_val("ready_at_32", 1);
    score(config_ready);
    commit();
    expect_val("ready_after_commit", 0); expect_val("err_after_commit", 0);
    score(config_ready); score(cfg_err);
    north_in = 4'b0001;
    expect_val("left_oe", 16'h0100); expect_val("left_out", 16'h0100);
    settle();
    score(all_oe); score(all_out);
    north_in = 4'b0000;
    expect_val("left_oe_in0", 16'h0100); expect_val("left_out_in0", 16'h0000);
    settle();
    score(all_oe); score(all_out);

    // South wire 3 turns right with twist onto east wire 0
    shift_bits(v_twist, 32);
    commit();
    south_in = 4'b1000;
    expect_val("twist_oe", 16'h0100); expect_val("twist_out", 16'h0100);
    settle();
    score(all_oe); score(all_out);

    // Short load is rejected and routing stays put
    shift_bits(v_other, 31);
    commit();
    expect_val("short_err", 1); expect_val("short_ready", 0);
    score(cfg_err); score(config_ready);
    expect_val("short_oe", 16'h0100); expect_val("short_out", 16'h0100);
    settle();
    score(all_oe); score(all_out);

    rst = 1'b1; step(); rst = 1'b0;
    south_in = '0;
    expect_val("err_cleared", 0);
    score(cfg_err);

    // Two sources on south wire 2; north wins
    shift_bits(v_cont, 32);
    commit();
    expect_val("cont_commit_edge", 0);
    score(contention);
    north_in = 4'b0000; east_in = 4'b0100;
    step();
    expect_val("cont_live", 1); expect_val("cont_sticky", 1);
    score(contention); score(contention_sticky);
    expect_val("cont_oe", 16'h0040); expect_val("cont_out_n0", 16'h0000);
    settle();
    score(all_oe); score(all_out);
    north_in = 4'b0100; east_in = 4'b0000;
    expect_val("cont_out_n1", 16'h0040);
    settle();
    score(all_out);

    // Enable gating
    en = 1'b0;
    expect_val("dis_oe", 0); expect_val("dis_out", 0); expect_val("dis_cont", 0);
    expect_val("dis_sticky", 1);
    settle();
    score(all_oe); score(all_out); score(contention); score(contention_sticky);
    en = 1'b1;
    step();
    expect_val("reen_oe", 16'h0040); expect_val("reen_out", 16'h0040); expect_val("reen_cont", 1);
    settle();
    score(all_oe); score(all_out); score(contention);

    // Accepted commit clears sticky contention
    north_in = 4'b0000;
    shift_bits(v_turn, 32);
    commit();
    expect_val("sticky_cleared", 0);
    score(contention_sticky);
    step();
    expect_val("cont_cleared", 0);
    score(contention);
    north_in = 4'b0001;
    expect_val("recfg_oe", 16'h0100); expect_val("recfg_out", 16'h0100);
    settle();
    score(all_oe); score(all_out);

    // Reset in the middle of a shift, with config_en still high
    for (int i = 0; i < 16; i++) begin
      config_en = 1'b1; config_data_in = 1'b0; step();
    end
    rst = 1'b1; step(); rst = 1'b0; config_en = 1'b0;
    expect_val("mid_ready", 0); expect_val("mid_data_out", 1);
    expect_val("mid_oe", 0); expect_val("mid_out", 0);
    #1;
    score(config_ready); score(config_data_out); score(all_oe); score(all_out);
    shift_bits(v_twist, 32);
    expect_val("count_from_zero", 1);
    score(config_ready);
    shift_bits(32'h0, 1);
    expect_val("ready_at_33", 0);
    score(config_ready);
    shift_bits(32'h0, 1);
    expect_val("ready_saturated", 0); expect_val("data_out_shifted", 0);
    score(config_ready); score(config_data_out);
    commit();
    expect_val("overlong_err", 1);
    score(cfg_err);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
